dpll_lock_controller: RTL and testbench
=======================================

// Module: dpll_lock_controller
// PURPOSE
//  Loop supervisor for the DPLL: configures the K-counter modulus (kMode) and divider ratio (multN),
//  sequences loop reset -> acquisition -> tracking -> locked, and reports lock.
//  Measures phase-detector error density over fixed windows. Uses the fast/low-K setting to acquire,
//  then gear-shifts to high K once the error stays low. Sits beside DPLL on the oscInput clock domain.
// PARAMETERS
//  WIN_LEN      256  window length in clk cycles (power of 2, >=16)
//  K_ACQ        3    kMode driven in RESET_LOOP/ACQUIRE
//  K_TRACK      6    kMode driven in TRACK/LOCKED
//  N_DEFAULT    4    multN after reset
//  LOCK_THR     16   window is "good" if err_total < LOCK_THR
//  UNLOCK_THR   64   window is "bad" if err_total >= UNLOCK_THR (UNLOCK_THR > LOCK_THR)
//  ACQ_GOOD     2    consecutive good windows ACQUIRE->TRACK
//  LOCK_GOOD    4    consecutive good windows TRACK->LOCKED
//  LOOP_RST_CYC 4    cycles loop_rst held high
// PORTS
//  clk        in  1  oscillator clock (same as DLF/IDCounter clock)
//  reset      in  1  asynchronous, active-low reset
//  err_sig    in  1  phase-detector XOR output (asynchronous to clk)
//  cfg_valid  in  1  request new divider ratio
//  cfg_n      in  8  requested multN
//  cfg_ready  out 1  controller accepts cfg this cycle
//  k_mode     out 4  to DLF kMode
//  mult_n     out 8  to NDivider N
//  loop_rst   out 1  active-high reset to DLF/IDCounter/NDivider
//  locked     out 1  lock indicator
//  state_dbg  out 2  current state code (debug)
// BEHAVIOUR
//  - Reset (reset=0, async): state=RESET_LOOP, rst_cnt=0, k_mode=K_ACQ, mult_n=N_DEFAULT,
//    loop_rst=1, locked=0, cfg_ready=0, window/err/good counters=0, sync flops=0.
//  - err_sig passes through a 2-flop synchronizer; err_s lags err_sig by 2 cycles.
//  - Window: win_cnt counts 0..WIN_LEN-1 and wraps. err_acc += err_s each cycle, saturating at 2^$clog2(WIN_LEN+1)-1.
//    At win_cnt==WIN_LEN-1, err_total = err_acc + err_s (this cycle included); win_done pulses 1 cycle; err_acc clears.
//    Window counters are held at 0 while in RESET_LOOP.
//  - States (2-bit): RESET_LOOP=0, ACQUIRE=1, TRACK=2, LOCKED=3. Outputs are registered.
//    RESET_LOOP: loop_rst=1, k_mode=K_ACQ. Stays LOOP_RST_CYC cycles, then ACQUIRE; good_cnt=0.
//    ACQUIRE: k_mode=K_ACQ. On win_done, good -> good_cnt++, else good_cnt=0.
//      When good_cnt reaches ACQ_GOOD -> TRACK, good_cnt=0.
//    TRACK: k_mode=K_TRACK. On win_done, good -> good_cnt++. bad -> ACQUIRE, good_cnt=0.
//      Between thresholds -> good_cnt=0. When good_cnt reaches LOCK_GOOD -> LOCKED.
//    LOCKED: locked=1, k_mode=K_TRACK. On win_done, bad -> ACQUIRE, locked=0 next cycle.
//      Good or intermediate windows keep lock (hysteresis).
//  - cfg handshake: cfg_ready=1 in ACQUIRE/TRACK/LOCKED, 0 in RESET_LOOP.
//    Transfer = cfg_valid&cfg_ready. On a transfer: mult_n <= max(cfg_n,2) next cycle, locked<=0,
//    state<=RESET_LOOP, and a fresh window starts after RESET_LOOP.
//    cfg_valid while cfg_ready=0 is held by the requester (no drop, no latch).
//  - Simultaneous transfer and win_done: the transfer wins and the window result is discarded.
//  - mult_n is stable except on a transfer. k_mode changes only on a state transition.
//  - Async reset mid-window/mid-RESET_LOOP returns all outputs to their reset values immediately.
// STRUCTURE
//  - dpll_defs.vh (shared include): state codes, K_ACQ/K_TRACK/N_DEFAULT defaults; reused by the DPLL top.
//  - Sub-module dpll_err_window: synchronizer + win_cnt + saturating err_acc.
//    Ports clk, reset, hold, err_sig -> win_done, err_total.
//  - Top: FSM, good_cnt, rst_cnt, cfg handshake, output registers.
// TESTING (WIN_LEN=32, LOCK_THR=4, UNLOCK_THR=12, defaults otherwise)
//  1 Release reset, err_sig=0 -> loop_rst=1 for 4 cycles, ACQUIRE, 2 windows later TRACK (k_mode 3->6),
//    4 windows later locked=1.
//  2 LOCKED, drive err_sig=1 for 8 of 32 cycles (intermediate) -> stays LOCKED;
//    then 12 of 32 -> ACQUIRE, locked=0, k_mode=3.
//  3 err_sig held 1 for whole window -> err_total=32 (no overflow), stays ACQUIRE, good_cnt=0.
//  4 LOCKED, cfg_valid=1 cfg_n=8 -> cfg_ready handshake 1 cycle, mult_n=8, loop_rst pulse 4 cycles,
//    relock sequence repeats. cfg_n=0 -> mult_n=2.
//  5 cfg transfer on win_done cycle with bad window -> RESET_LOOP (not ACQUIRE).
//    cfg_valid during RESET_LOOP -> cfg_ready=0, accepted on first ACQUIRE cycle.
//  6 Assert reset in TRACK mid-window -> all outputs at reset values without a clk edge.

Source files
------------

// File: rtl/dpll_lock_controller_pkg.sv
// Shared definitions for the DPLL lock supervisor: state codes, loop defaults
// and the divider-ratio clamp applied to configuration requests.
package dpll_lock_controller_pkg;

    typedef enum logic [1:0] {
        ST_RESET_LOOP = 2'd0,
        ST_ACQUIRE    = 2'd1,
        ST_TRACK      = 2'd2,
        ST_LOCKED     = 2'd3
    } state_e;

    localparam int K_ACQ_DEF     = 3;
    localparam int K_TRACK_DEF   = 6;
    localparam int N_DEFAULT_DEF = 4;
    localparam int N_MIN         = 2;

    // The N divider cannot run below a ratio of 2.
    function automatic logic [7:0] clamp_n(input logic [7:0] n);
        return (n < 8'(N_MIN)) ? 8'(N_MIN) : n;
    endfunction

endpackage

// File: rtl/dpll_lock_controller_if.sv
// Control/status bundle between the DPLL datapath (master) and the lock
// supervisor (slave).
interface dpll_lock_controller_if;
    logic       err_sig;
    logic       cfg_valid;
    logic [7:0] cfg_n;
    logic       cfg_ready;
    logic [3:0] k_mode;
    logic [7:0] mult_n;
    logic       loop_rst;
    logic       locked;
    logic [1:0] state_dbg;

    modport master (
        output err_sig, cfg_valid, cfg_n,
        input  cfg_ready, k_mode, mult_n, loop_rst, locked, state_dbg
    );

    modport slave (
        input  err_sig, cfg_valid, cfg_n,
        output cfg_ready, k_mode, mult_n, loop_rst, locked, state_dbg
    );
endinterface

// File: rtl/dpll_err_window.sv
// Phase-error density meter: synchronises the XOR detector output and counts
// its high cycles over fixed WIN_LEN-cycle windows.
module dpll_err_window #(
    parameter  int WIN_LEN = 256,
    localparam int CNT_W   = $clog2(WIN_LEN),
    localparam int ACC_W   = $clog2(WIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_hold,
    input  logic             i_err_sig,
    output logic             o_win_done,
    output logic [ACC_W-1:0] o_err_total
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_win_cnt;
    logic [ACC_W-1:0] r_err_acc;
    logic [ACC_W-1:0] w_acc_inc;
    logic             w_last;

    assign w_last    = (r_win_cnt == CNT_W'(WIN_LEN - 1));
    assign w_acc_inc = (r_err_acc == ACC_MAX) ? ACC_MAX : r_err_acc + ACC_W'(r_sync2);

    assign o_win_done  = w_last & ~i_hold;
    assign o_err_total = w_acc_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two sync stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_err_sig;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt <= '0;
            r_err_acc <= '0;
        end else if (i_hold || w_last) begin
            r_win_cnt <= '0;
            r_err_acc <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            r_err_acc <= w_acc_inc;
        end
    end

endmodule

// File: rtl/dpll_lock_controller.sv
// DPLL loop supervisor: sequences loop reset, acquisition, tracking and lock,
// gear-shifts the loop filter K and accepts divider-ratio reconfiguration.
module dpll_lock_controller
    import dpll_lock_controller_pkg::*;
#(
    parameter int WIN_LEN      = 256,
    parameter int K_ACQ        = K_ACQ_DEF,
    parameter int K_TRACK      = K_TRACK_DEF,
    parameter int N_DEFAULT    = N_DEFAULT_DEF,
    parameter int LOCK_THR     = 16,
    parameter int UNLOCK_THR   = 64,
    parameter int ACQ_GOOD     = 2,
    parameter int LOCK_GOOD    = 4,
    parameter int LOOP_RST_CYC = 4
) (
    input logic                   clk,
    input logic                   reset,
    dpll_lock_controller_if.slave bus
);

    localparam int ACC_W  = $clog2(WIN_LEN + 1);
    localparam int GOOD_W = $clog2(ACQ_GOOD + LOCK_GOOD + 1);
    localparam int RST_W  = $clog2(LOOP_RST_CYC + 1);

    state_e              r_state,     w_state_nxt;
    logic [RST_W-1:0]    r_rst_cnt,   w_rst_cnt_nxt;
    logic [GOOD_W-1:0]   r_good_cnt,  w_good_nxt;
    logic [7:0]          r_mult_n,    w_mult_nxt;
    logic [3:0]          r_k_mode,    w_k_mode_nxt;
    logic                r_loop_rst,  w_loop_rst_nxt;
    logic                r_locked,    w_locked_nxt;
    logic                r_cfg_ready, w_cfg_ready_nxt;

    logic                w_win_done;
    logic [ACC_W-1:0]    w_err_total;
    logic                w_good;
    logic                w_bad;
    logic                w_xfer;

    dpll_err_window #(.WIN_LEN(WIN_LEN)) u_win (
        .clk         (clk),
        .reset       (reset),
        .i_hold      (r_state == ST_RESET_LOOP),
        .i_err_sig   (bus.err_sig),
        .o_win_done  (w_win_done),
        .o_err_total (w_err_total)
    );

    assign w_good = 32'(w_err_total) < LOCK_THR;
    assign w_bad  = 32'(w_err_total) >= UNLOCK_THR;
    assign w_xfer = bus.cfg_valid & r_cfg_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RESET_LOOP;
            r_rst_cnt   <= '0;
            r_good_cnt  <= '0;
            r_mult_n    <= 8'(N_DEFAULT);
            r_k_mode    <= 4'(K_ACQ);
            r_loop_rst  <= 1'b1;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_good_cnt  <= w_good_nxt;
            r_mult_n    <= w_mult_nxt;
            r_k_mode    <= w_k_mode_nxt;
            r_loop_rst  <= w_loop_rst_nxt;
            r_locked    <= w_locked_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
        end
    end

    // A configuration transfer outranks any window verdict in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before the branches; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_good_nxt    = r_good_cnt;
        w_mult_nxt    = r_mult_n;
        if (w_xfer) begin
            w_state_nxt   = ST_RESET_LOOP;
            w_rst_cnt_nxt = '0;
            w_good_nxt    = '0;
            w_mult_nxt    = clamp_n(bus.cfg_n);
        end else begin
            unique case (r_state)
                ST_RESET_LOOP: begin
                    w_good_nxt = '0;
                    if (r_rst_cnt == RST_W'(LOOP_RST_CYC - 1)) begin
                        w_state_nxt   = ST_ACQUIRE;
                        w_rst_cnt_nxt = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                ST_ACQUIRE: if (w_win_done) begin
                    if (!w_good) begin
                        w_good_nxt = '0;
                    end else if (r_good_cnt == GOOD_W'(ACQ_GOOD - 1)) begin
                        w_state_nxt = ST_TRACK;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
                ST_TRACK: if (w_win_done) begin
                    if (w_bad) begin
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = '0;
                    end else if (!w_good) begin
                        w_good_nxt = '0;
                    end else if (r_good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
                ST_LOCKED: if (w_win_done && w_bad) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                end
                default: w_state_nxt = ST_RESET_LOOP;
            endcase
        end
    end

    // Outputs decode the next state so they register alongside it.
    always_comb begin
        w_k_mode_nxt    = (w_state_nxt == ST_TRACK || w_state_nxt == ST_LOCKED)
                          ? 4'(K_TRACK) : 4'(K_ACQ);
        w_loop_rst_nxt  = (w_state_nxt == ST_RESET_LOOP);
        w_locked_nxt    = (w_state_nxt == ST_LOCKED);
        w_cfg_ready_nxt = (w_state_nxt != ST_RESET_LOOP);
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.k_mode    = r_k_mode;
    assign bus.mult_n    = r_mult_n;
    assign bus.loop_rst  = r_loop_rst;
    assign bus.locked    = r_locked;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_dpll_lock_controller.sv
// Directed bench for dpll_lock_controller: window-level vector table plus
// hand-written sequences for configuration handshakes and async reset.
module tb_dpll_lock_controller;

    localparam int WIN = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dpll_lock_controller_if ifc();

    dpll_lock_controller #(
        .WIN_LEN    (WIN),
        .LOCK_THR   (4),
        .UNLOCK_THR (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int first;  // first window cycle with err_sig high
        int n;      // number of high cycles
        int st;     // expected state after the window
        int k;      // expected k_mode
        int lk;     // expected locked
    } win_vec_t;

    win_vec_t vecs[$];

    function automatic void add(int first, int n, int st, int k, int lk);
        vecs.push_back('{first, n, st, k, lk});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int st, input int k,
                              input int lk, input int mn);
        check({tag, ".state"},  int'(ifc.state_dbg), st);
        check({tag, ".k_mode"}, int'(ifc.k_mode),    k);
        check({tag, ".locked"}, int'(ifc.locked),    lk);
        check({tag, ".mult_n"}, int'(ifc.mult_n),    mn);
    endtask

    task automatic run_window(input int first, input int n);
        for (int t = 0; t < WIN; t++) begin
            ifc.err_sig = (t >= first) && (t < first + n);
            tick();
        end
        ifc.err_sig = 1'b0;
    endtask

    initial begin
        ifc.err_sig   = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_n     = 8'd0;

        // Error bursts start at cycle 4 so the 2-cycle sync lag stays in-window.
        add(4, 0, 1, 3, 0);
        add(4, 0, 2, 6, 0);
        for (int i = 0; i < 3; i++) add(4, 0, 2, 6, 0);
        add(4, 0, 3, 6, 1);
        add(4, 8, 3, 6, 1);     // intermediate keeps lock
        add(4, 3, 3, 6, 1);     // good keeps lock
        add(4, 12, 1, 3, 0);    // exactly UNLOCK_THR drops lock
        add(4, 0, 1, 3, 0);
        add(4, 5, 1, 3, 0);     // intermediate clears acquire count
        add(4, 0, 1, 3, 0);
        add(4, 0, 2, 6, 0);
        add(4, 0, 2, 6, 0);
        add(4, 11, 2, 6, 0);    // just below UNLOCK_THR
        for (int i = 0; i < 3; i++) add(4, 0, 2, 6, 0);
        add(4, 4, 2, 6, 0);     // exactly LOCK_THR is not good
        add(4, 0, 2, 6, 0);
        add(4, 20, 1, 3, 0);    // bad in TRACK
        add(4, 0, 1, 3, 0);
        add(4, 0, 2, 6, 0);
        for (int i = 0; i < 3; i++) add(4, 0, 2, 6, 0);
        add(4, 3, 3, 6, 1);
        add(0, 32, 1, 3, 0);    // 30 counted (sync lag)
        add(0, 32, 1, 3, 0);    // full window: 32, no wrap
        add(0, 32, 1, 3, 0);
        add(4, 0, 1, 3, 0);     // 2 lagging errors: good
        add(4, 0, 2, 6, 0);
        for (int i = 0; i < 3; i++) add(4, 0, 2, 6, 0);
        add(4, 0, 3, 6, 1);

        // Reset values while reset is held
        #12;
        check_outs("rst", 0, 3, 0, 4);
        check("rst.loop_rst",  int'(ifc.loop_rst),  1);
        check("rst.cfg_ready", int'(ifc.cfg_ready), 0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("boot%0d.loop_rst", i), int'(ifc.loop_rst), 1);
            check($sformatf("boot%0d.state", i),    int'(ifc.state_dbg), 0);
        end
        tick();
        check_outs("boot4", 1, 3, 0, 4);
        check("boot4.loop_rst",  int'(ifc.loop_rst),  0);
        check("boot4.cfg_ready", int'(ifc.cfg_ready), 1);

        foreach (vecs[i]) begin
            run_window(vecs[i].first, vecs[i].n);
            check_outs($sformatf("win%0d", i), vecs[i].st, vecs[i].k, vecs[i].lk, 4);
        end

        // Reconfigure from LOCKED mid-window: cfg_n=8
        for (int i = 0; i < 10; i++) tick();
        check("cfg8.ready_before", int'(ifc.cfg_ready), 1);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_n     = 8'd8;
        tick();
        ifc.cfg_valid = 1'b0;
        check_outs("cfg8", 0, 3, 0, 8);
        check("cfg8.loop_rst",  int'(ifc.loop_rst),  1);
        check("cfg8.cfg_ready", int'(ifc.cfg_ready), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("cfg8_rst%0d.loop_rst", i), int'(ifc.loop_rst), 1);
        end
        tick();
        check("cfg8_acq.loop_rst", int'(ifc.loop_rst), 0);
        check("cfg8_acq.state",    int'(ifc.state_dbg), 1);
        for (int w = 0; w < 6; w++) begin
            run_window(4, 0);
            check_outs($sformatf("relock%0d", w),
                       (w == 0) ? 1 : (w < 5) ? 2 : 3,
                       (w == 0) ? 3 : 6,
                       (w == 5) ? 1 : 0, 8);
        end

        // cfg_n=0 clamps to 2; a request held through RESET_LOOP waits
        for (int i = 0; i < 3; i++) tick();
        ifc.cfg_valid = 1'b1;
        ifc.cfg_n     = 8'd0;
        tick();
        ifc.cfg_n = 8'd6;
        check_outs("cfg0", 0, 3, 0, 2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("hold%0d.cfg_ready", i), int'(ifc.cfg_ready), 0);
            check($sformatf("hold%0d.mult_n", i),    int'(ifc.mult_n),    2);
        end
        tick();
        check("hold4.state",     int'(ifc.state_dbg), 1);
        check("hold4.cfg_ready", int'(ifc.cfg_ready), 1);
        check("hold4.mult_n",    int'(ifc.mult_n),    2);
        tick();
        ifc.cfg_valid = 1'b0;
        check_outs("cfg6", 0, 3, 0, 6);
        for (int i = 0; i < 4; i++) tick();
        check("cfg6_acq.state", int'(ifc.state_dbg), 1);

        // Transfer on the win_done cycle of a bad window
        for (int t = 0; t < WIN - 1; t++) begin
            ifc.err_sig = (t >= 4) && (t < 24);
            tick();
        end
        ifc.err_sig   = 1'b0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_n     = 8'd5;
        tick();
        ifc.cfg_valid = 1'b0;
        check_outs("xfer_win", 0, 3, 0, 5);
        check("xfer_win.loop_rst", int'(ifc.loop_rst), 1);
        for (int i = 0; i < 4; i++) tick();
        check("xfer_acq.state", int'(ifc.state_dbg), 1);
        run_window(4, 0);
        run_window(4, 0);
        check_outs("xfer_track", 2, 6, 0, 5);

        // Async reset in TRACK mid-window, no clock edge before sampling
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check_outs("areset", 0, 3, 0, 4);
        check("areset.loop_rst",  int'(ifc.loop_rst),  1);
        check("areset.cfg_ready", int'(ifc.cfg_ready), 0);
        #20;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_outs("reboot", 1, 3, 0, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
